// File: rtl/db_lcu_ram_arb_if.sv
// Bus bundle between the two LCU RAM requesters, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view. The master modport is the view of the requesters
// and the RAM: it drives the requests and rdata_i and observes the grants.
interface db_lcu_ram_arb_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 8
);
  // requester 0: filter write-back
  logic                  req0_i;
  logic                  we0_i;
  logic [ADDR_WIDTH-1:0] addr0_i;
  logic [DATA_WIDTH-1:0] data0_i;
  logic                  gnt0_o;
  logic                  rvld0_o;
  // requester 1: output fetch
  logic                  req1_i;
  logic                  we1_i;
  logic [ADDR_WIDTH-1:0] addr1_i;
  logic [DATA_WIDTH-1:0] data1_i;
  logic                  gnt1_o;
  logic                  rvld1_o;
  // shared read data
  logic [DATA_WIDTH-1:0] rdata_o;
  // RAM side
  logic                  cen_o;
  logic                  wen_o;
  logic                  ren_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic [DATA_WIDTH-1:0] rdata_i;

  modport slave (
    input  req0_i, we0_i, addr0_i, data0_i,
    input  req1_i, we1_i, addr1_i, data1_i,
    input  rdata_i,
    output gnt0_o, rvld0_o, gnt1_o, rvld1_o, rdata_o,
    output cen_o, wen_o, ren_o, addr_o, data_o
  );

  modport master (
    output req0_i, we0_i, addr0_i, data0_i,
    output req1_i, we1_i, addr1_i, data1_i,
    output rdata_i,
    input  gnt0_o, rvld0_o, gnt1_o, rvld1_o, rdata_o,
    input  cen_o, wen_o, ren_o, addr_o, data_o
  );
endinterface

// File: rtl/db_lcu_ram_arb.sv
// Two-requester arbiter in front of a single-port LCU pixel RAM.
// The grant is combinational, so an access completes at the edge that ends its grant cycle.
// Read data returns one cycle later, qualified by the owner's rvld.
// Arbitration policy:
// - default build: fixed priority to requester 0, with a starvation guard for requester 1.
// - DB_LCU_RAM_ARB_RR_EN defined: round-robin on contended cycles.
module db_lcu_ram_arb #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  db_lcu_ram_arb_if.slave  bus
);

  logic                  gnt0;
  logic                  gnt1;
  logic                  contended;
  logic [1:0]            rvld_q;

  assign contended = bus.req0_i & bus.req1_i;

`ifdef DB_LCU_RAM_ARB_RR_EN
  // 0: requester 0 wins the next contended cycle, 1: requester 1 wins it
  logic rr_ptr_q;

  // Pick the winner: the pointer settles contention, a lone requester always wins.
  // Grants are gated off while rst is high.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (contended) begin
        gnt0 = ~rr_ptr_q;
        gnt1 = rr_ptr_q;
      end else begin
        gnt0 = bus.req0_i;
        gnt1 = bus.req1_i;
      end
    end
  end

  // Hand priority to the loser, and only on cycles that were actually contended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else if (contended) begin
      rr_ptr_q <= gnt0;
    end
  end
`else
  // The counter is at least 3 bits wide, and wider when STARVE_MAX needs more bits.
  localparam int unsigned CntW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

  logic [CntW-1:0] starve_cnt_q;
  logic            starve_hit;

  assign starve_hit = (starve_cnt_q == CntW'(STARVE_MAX));

  // Requester 0 wins contention unless requester 1 has been starved long enough.
  // A lone requester always wins. Grants are gated off while rst is high.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (contended) begin
        gnt0 = ~starve_hit;
        gnt1 = starve_hit;
      end else begin
        gnt0 = bus.req0_i;
        gnt1 = bus.req1_i;
      end
    end
  end

  // Count the cycles in which requester 1 waits; clear once it is served or drops its request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else if (gnt1 || !bus.req1_i) begin
      starve_cnt_q <= '0;
    end else if (starve_cnt_q < CntW'(STARVE_MAX)) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end
`endif

  // Steer the winner onto the RAM port. When idle the port is disabled and the bus is zeroed.
  always_comb begin
    bus.cen_o  = 1'b1;
    bus.wen_o  = 1'b1;
    bus.addr_o = '0;
    bus.data_o = '0;
    if (gnt0) begin
      bus.cen_o  = 1'b0;
      bus.wen_o  = ~bus.we0_i;
      bus.addr_o = bus.addr0_i;
      bus.data_o = bus.data0_i;
    end else if (gnt1) begin
      bus.cen_o  = 1'b0;
      bus.wen_o  = ~bus.we1_i;
      bus.addr_o = bus.addr1_i;
      bus.data_o = bus.data1_i;
    end
  end

  // Track which owner's read is in flight.
  // The asynchronous reset drops any read that was granted while rst was high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvld_q <= 2'b00;
    end else begin
      rvld_q <= {gnt1 & ~bus.we1_i, gnt0 & ~bus.we0_i};
    end
  end

  // Grants and the read-return qualifiers
  always_comb begin
    bus.gnt0_o  = gnt0;
    bus.gnt1_o  = gnt1;
    bus.rvld0_o = rvld_q[0];
    bus.rvld1_o = rvld_q[1];
    bus.ren_o   = ~(rvld_q[0] | rvld_q[1]);
    bus.rdata_o = bus.rdata_i;
  end

endmodule

// File: tb/tb_db_lcu_ram_arb.sv
// Directed bench for db_lcu_ram_arb.
// It includes a behavioural single-port RAM model with 1-cycle read latency.
module tb_db_lcu_ram_arb;
  localparam int unsigned DW = 128;
  localparam int unsigned AW = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] pat_a5;
  logic [DW-1:0] pat_d0;
  logic [DW-1:0] pat_d1;

  db_lcu_ram_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  db_lcu_ram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write when cen=0 and wen=0; read data appears after the access edge.
  always @(posedge clk) begin
    if (!bus.cen_o && !bus.wen_o) mem[bus.addr_o] <= bus.data_o;
    if (!bus.cen_o && bus.wen_o) bus.rdata_i <= mem[bus.addr_o];
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    pat_a5 = {16{8'hA5}};
    pat_d0 = {4{32'h1234_5678}};
    pat_d1 = {4{32'hCAFE_F00D}};
    bus.rdata_i = '0;
    // Requests are held active during reset: the outputs must still show reset values.
    rst = 1'b1;
    bus.req0_i = 1'b1; bus.we0_i = 1'b0; bus.addr0_i = 8'h33; bus.data0_i = pat_d0;
    bus.req1_i = 1'b1; bus.we1_i = 1'b1; bus.addr1_i = 8'h44; bus.data1_i = pat_d1;
    step(); step();
    #2;
    chk("rst_gnt0", bus.gnt0_o, 0);
    chk("rst_gnt1", bus.gnt1_o, 0);
    chk("rst_cen", bus.cen_o, 1);
    chk("rst_wen", bus.wen_o, 1);
    chk("rst_ren", bus.ren_o, 1);
    chk("rst_rvld0", bus.rvld0_o, 0);
    chk("rst_rvld1", bus.rvld1_o, 0);
    chk("rst_addr", bus.addr_o, 0);
    chk("rst_data", bus.data_o, 0);

    // Release reset; in the very next cycle requester 0 alone writes A5.. to address 0x10.
    step();
    rst = 1'b0;
    bus.req1_i = 1'b0;
    bus.req0_i = 1'b1; bus.we0_i = 1'b1; bus.addr0_i = 8'h10; bus.data0_i = pat_a5;
    #2;
    chk("wr_gnt0", bus.gnt0_o, 1);
    chk("wr_gnt1", bus.gnt1_o, 0);
    chk("wr_cen", bus.cen_o, 0);
    chk("wr_wen", bus.wen_o, 0);
    chk("wr_addr", bus.addr_o, 8'h10);
    chk("wr_data", bus.data_o, pat_a5);

    // Requester 1 reads address 0x10 in the following cycle.
    step();
    bus.req0_i = 1'b0;
    bus.req1_i = 1'b1; bus.we1_i = 1'b0; bus.addr1_i = 8'h10;
    #2;
    chk("ram_word_10", mem[8'h10], pat_a5);
    chk("rd_gnt1", bus.gnt1_o, 1);
    chk("rd_gnt0", bus.gnt0_o, 0);
    chk("rd_cen", bus.cen_o, 0);
    chk("rd_wen", bus.wen_o, 1);
    chk("rd_addr", bus.addr_o, 8'h10);
    step();
    bus.req1_i = 1'b0;
    #2;
    chk("rd_rvld1", bus.rvld1_o, 1);
    chk("rd_rvld0", bus.rvld0_o, 0);
    chk("rd_ren", bus.ren_o, 0);
    chk("rd_rdata", bus.rdata_o, pat_a5);
    chk("rd_idle_cen", bus.cen_o, 1);

    // Both requesters hold write requests continuously.
    // Requester 0 writes D0 to address 0x20 and requester 1 writes D1 to address 0x30.
    step();
    bus.req0_i = 1'b1; bus.we0_i = 1'b1; bus.addr0_i = 8'h20; bus.data0_i = pat_d0;
    bus.req1_i = 1'b1; bus.we1_i = 1'b1; bus.addr1_i = 8'h30; bus.data1_i = pat_d1;
    #2;
    chk("idle_ren", bus.ren_o, 1);
    chk("idle_rvld1", bus.rvld1_o, 0);
    for (int i = 0; i < 10; i++) begin
`ifdef DB_LCU_RAM_ARB_RR_EN
      chk($sformatf("cont_gnt1_%0d", i), bus.gnt1_o, (i % 2) == 1);
`else
      chk($sformatf("cont_gnt1_%0d", i), bus.gnt1_o, (i == 4) || (i == 9));
`endif
      chk($sformatf("cont_onehot_%0d", i), bus.gnt0_o ^ bus.gnt1_o, 1);
      step();
      #2;
    end

    // Alternating single reads: requester 0 reads 0x20, then requester 1 reads 0x30.
    step();
    for (int i = 0; i < 4; i++) begin
      bus.req0_i = (i % 2) == 0; bus.we0_i = 1'b0; bus.addr0_i = 8'h20;
      bus.req1_i = (i % 2) == 1; bus.we1_i = 1'b0; bus.addr1_i = 8'h30;
      #2;
      chk($sformatf("alt_gnt0_%0d", i), bus.gnt0_o, (i % 2) == 0);
      chk($sformatf("alt_gnt1_%0d", i), bus.gnt1_o, (i % 2) == 1);
      if (i > 0) begin
        chk($sformatf("alt_rvld0_%0d", i), bus.rvld0_o, (i % 2) == 1);
        chk($sformatf("alt_rvld1_%0d", i), bus.rvld1_o, (i % 2) == 0);
        chk($sformatf("alt_ren_%0d", i), bus.ren_o, 0);
        chk($sformatf("alt_rdata_%0d", i), bus.rdata_o, ((i % 2) == 1) ? pat_d0 : pat_d1);
      end
      step();
    end
    bus.req0_i = 1'b0;
    bus.req1_i = 1'b0;
    #2;
    chk("alt_last_rvld1", bus.rvld1_o, 1);
    chk("alt_last_rdata", bus.rdata_o, pat_d1);
    step();
    #2;
    chk("alt_end_ren", bus.ren_o, 1);

    // Reset pulsed in the grant cycle of a read: that read must not return.
    step();
    bus.req0_i = 1'b1; bus.we0_i = 1'b0; bus.addr0_i = 8'h20;
    #1;
    chk("rstrd_gnt_before", bus.gnt0_o, 1);
    rst = 1'b1;
    #1;
    chk("rstrd_gnt0", bus.gnt0_o, 0);
    chk("rstrd_cen", bus.cen_o, 1);
    chk("rstrd_wen", bus.wen_o, 1);
    chk("rstrd_addr", bus.addr_o, 0);
    step();
    #2;
    chk("rstrd_rvld0_in_rst", bus.rvld0_o, 0);
    chk("rstrd_ren_in_rst", bus.ren_o, 1);
    rst = 1'b0;
    bus.req0_i = 1'b0;
    step();
    #2;
    chk("rstrd_rvld0_after", bus.rvld0_o, 0);
    chk("rstrd_ren_after", bus.ren_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
